// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: two-port round-robin access controller for a byte-wide,
// synchronous-read data memory. Each byte/half/word request is split into
// big-endian byte beats; loads return sign- or zero-extended data with a
// one-cycle acknowledge.
// Optional feature macro: DMEM_ACCESS_CTRL_ALIGN_CHECK_EN (when defined,
// misaligned half/word requests are rejected with err instead of executed).
module dmem_access_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    input  logic              we0,
    input  logic              we1,
    input  logic [1:0]        size0,
    input  logic [1:0]        size1,
    input  logic              sgn0,
    input  logic              sgn1,
    output logic              ack0,
    output logic              ack1,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_last;      // port granted most recently
    logic                r_port;      // port owning the current access
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_sgn;
    logic [1:0]          r_beat;      // index of the beat currently on the bus
    logic [31:0]         r_wsh;       // remaining store bytes, next byte in [31:24]
    logic [31:0]         r_acc;       // load byte accumulator
    logic                r_ack0;
    logic                r_ack1;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic                r_busy;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_wdata;

    logic        w_port;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_we;
    logic [1:0]  w_size;
    logic        w_sgn;
    logic        w_misalign;
    logic        w_bad;
    logic [31:0] w_wsh;
    logic [31:0] w_acc_sh;
    logic [31:0] w_ext;
    logic [1:0]  w_last_idx;
    logic        w_unused_bits;

    // On a tie the port that did not win last time is granted.
    assign w_port  = (req0 && req1) ? ~r_last : req1;
    assign w_addr  = w_port ? addr1  : addr0;
    assign w_wdata = w_port ? wdata1 : wdata0;
    assign w_we    = w_port ? we1    : we0;
    assign w_size  = w_port ? size1  : size0;
    assign w_sgn   = w_port ? sgn1   : sgn0;

`ifdef DMEM_ACCESS_CTRL_ALIGN_CHECK_EN
    assign w_misalign = ((w_size == 2'b01) && w_addr[0]) ||
                        ((w_size == 2'b10) && (w_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_bad      = (w_size == 2'b11) || w_misalign;
    assign w_last_idx = {r_size[1], r_size[1] | r_size[0]};   // N-1 for 1/2/4 beats
    assign w_acc_sh   = {r_acc[23:0], mem_rdata};

    // Only the low ADDR_W address bits select a byte; the rest are ignored.
    assign w_unused_bits = ^{addr0[31:ADDR_W], addr1[31:ADDR_W]};

    // Left-justify store data so beats can be taken MSB first from [31:24].
    always_comb begin
        w_wsh = w_wdata;
        case (w_size)
            2'b00:   w_wsh = {w_wdata[7:0], 24'h0};
            2'b01:   w_wsh = {w_wdata[15:0], 16'h0};
            default: w_wsh = w_wdata;
        endcase
    end

    // Extend the completed accumulator (including the final byte) to 32 bits.
    always_comb begin
        w_ext = w_acc_sh;
        case (r_size)
            2'b00:   w_ext = {{24{r_sgn & w_acc_sh[7]}}, w_acc_sh[7:0]};
            2'b01:   w_ext = {{16{r_sgn & w_acc_sh[15]}}, w_acc_sh[15:0]};
            default: w_ext = w_acc_sh;
        endcase
    end

    // Arbitration, beat sequencing and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_port      <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_sgn       <= 1'b0;
            r_beat      <= 2'b00;
            r_wsh       <= 32'h0;
            r_acc       <= 32'h0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_port <= w_port;
                        r_last <= w_port;
                        r_we   <= w_we;
                        r_size <= w_size;
                        r_sgn  <= w_sgn;
                        r_beat <= 2'b00;
                        r_acc  <= 32'h0;
                        r_busy <= 1'b1;
                        if (w_bad) begin
                            r_state <= S_RESP;
                            r_err   <= 1'b1;
                            r_rdata <= 32'h0;
                            r_ack0  <= ~w_port;
                            r_ack1  <= w_port;
                        end else begin
                            r_state     <= S_XFER;
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= w_we;
                            r_mem_addr  <= w_addr[ADDR_W-1:0];
                            r_mem_wdata <= w_we ? w_wsh[31:24] : 8'h0;
                            r_wsh       <= {w_wsh[23:0], 8'h0};
                        end
                    end
                end
                S_XFER: begin
                    // Read data of the previous beat arrives this cycle.
                    if (r_beat != 2'b00) begin
                        r_acc <= w_acc_sh;
                    end
                    if (r_beat == w_last_idx) begin
                        r_mem_en    <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= 8'h0;
                        if (r_we) begin
                            r_state <= S_RESP;
                            r_rdata <= 32'h0;
                            r_ack0  <= ~r_port;
                            r_ack1  <= r_port;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_beat      <= r_beat + 2'd1;
                        r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                        r_mem_wdata <= r_we ? r_wsh[31:24] : 8'h0;
                        r_wsh       <= {r_wsh[23:0], 8'h0};
                    end
                end
                S_WAIT: begin
                    r_acc   <= w_acc_sh;
                    r_rdata <= w_ext;
                    r_state <= S_RESP;
                    r_ack0  <= ~r_port;
                    r_ack1  <= r_port;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_rdata <= 32'h0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign rdata     = r_rdata;
    assign err       = r_err;
    assign busy      = r_busy;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl with a 256-byte
// synchronous-read memory model attached to the beat interface.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        we0, we1;
    logic [1:0]  size0, size1;
    logic        sgn0, sgn1;
    logic        ack0, ack1;
    logic [31:0] rdata;
    logic        err, busy, mem_en, mem_we;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Beat log and status captured by the request driver.
    logic [7:0] b_addr [8];
    logic [7:0] b_data [8];
    logic       b_we   [8];
    int         n_beats;
    logic       busy1, busy_after, stray;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    // Byte-wide memory, read data registered one cycle after the address.
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    dmem_access_ctrl #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1),
        .size0(size0), .size1(size1),
        .sgn0(sgn0), .sgn1(sgn1),
        .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .err(err), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Issue one request from an IDLE cycle (called just after a negedge);
    // cycle 0 is the current cycle. Returns after the IDLE cycle following ack.
    task automatic do_req(input bit p, input logic [31:0] a, input logic [31:0] wd,
                          input logic w, input logic [1:0] sz, input logic sg,
                          output int ack_cyc, output logic [31:0] rd, output logic e);
        if (!p) begin req0 = 1; addr0 = a; wdata0 = wd; we0 = w; size0 = sz; sgn0 = sg; end
        else    begin req1 = 1; addr1 = a; wdata1 = wd; we1 = w; size1 = sz; sgn1 = sg; end
        n_beats = 0; ack_cyc = -1; rd = 32'h0; e = 1'b0; stray = 1'b0; busy1 = 1'b0;
        for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = busy;
            if (mem_en && n_beats < 8) begin
                b_addr[n_beats] = mem_addr; b_data[n_beats] = mem_wdata;
                b_we[n_beats] = mem_we; n_beats++;
            end
            if ((p ? ack1 : ack0) === 1'b1) begin
                ack_cyc = c; rd = rdata; e = err;
                if (!p) req0 = 0; else req1 = 0;
                if ((p ? ack0 : ack1) !== 1'b0) stray = 1'b1;
            end else if (rdata !== 32'h0 || err !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
                stray = 1'b1;
            end
        end
        req0 = 0; req1 = 0;
        @(negedge clk);
        busy_after = busy;
    endtask

    task automatic apply_reset();
        rst = 0; req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0; req0 = 0; req1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        we0 = 0; we1 = 0; size0 = 0; size1 = 0; sgn0 = 0; sgn1 = 0;
        repeat (3) @(negedge clk);
        n_checks++; if ({ack0, ack1, err, busy, mem_en, mem_we} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {ack0, ack1, err, busy, mem_en, mem_we}); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
        n_checks++; if ({mem_addr, mem_wdata} !== 16'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h expected 0000", {mem_addr, mem_wdata}); end
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_word();
        int ac; logic [31:0] rd; logic e;
        logic [31:0] wv;
        wv = 32'hDEADBEEF;
        do_req(0, 32'hABCD_0010, wv, 1, 2'b10, 0, ac, rd, e);
        $display("word store 0x10: ack_cycle=%0d beats=%0d", ac, n_beats);
        n_checks++; if (ac !== 5) begin n_fail++; $display("FAIL word_st_ack: got %0d expected 5", ac); end
        n_checks++; if (n_beats !== 4) begin n_fail++; $display("FAIL word_st_beats: got %0d expected 4", n_beats); end
        for (int k = 0; k < 4; k++) begin
            logic [7:0] ea;
            ea = 8'h10 + 8'(k);
            n_checks++;
            if ({b_addr[k], b_data[k], b_we[k]} !== {ea, wv[31-8*k -: 8], 1'b1}) begin
                n_fail++; $display("FAIL word_st_beat%0d: got addr=%h data=%h we=%b expected addr=%h data=%h we=1", k, b_addr[k], b_data[k], b_we[k], ea, wv[31-8*k -: 8]);
            end
        end
        n_checks++; if ({e, rd} !== 33'h0) begin n_fail++; $display("FAIL word_st_resp: got err=%b rdata=%h expected 0/0", e, rd); end
        n_checks++; if ({busy1, busy_after, stray} !== 3'b100) begin n_fail++; $display("FAIL word_st_busy: got busy1=%b busy_after=%b stray=%b expected 1/0/0", busy1, busy_after, stray); end
        do_req(0, 32'h0000_0010, 32'h0, 0, 2'b10, 0, ac, rd, e);
        $display("word load 0x10: ack_cycle=%0d rdata=%h", ac, rd);
        n_checks++; if (ac !== 6) begin n_fail++; $display("FAIL word_ld_ack: got %0d expected 6", ac); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_ld_data: got %h expected deadbeef", rd); end
        n_checks++; if ({n_beats, b_we[0], b_we[3], stray} !== {32'd4, 3'b000}) begin n_fail++; $display("FAIL word_ld_beats: got n=%0d we0=%b we3=%b stray=%b expected 4/0/0/0", n_beats, b_we[0], b_we[3], stray); end
    endtask

    task automatic test_sign_ext();
        int ac; logic [31:0] rd; logic e;
        do_req(0, 32'h20, 32'hFFFF_FF80, 1, 2'b00, 0, ac, rd, e);
        $display("byte store 0x20: ack_cycle=%0d", ac);
        n_checks++; if ({ac, b_data[0]} !== {32'd2, 8'h80}) begin n_fail++; $display("FAIL byte_st: got ack=%0d data=%h expected 2/80", ac, b_data[0]); end
        do_req(0, 32'h20, 32'h0, 0, 2'b00, 1, ac, rd, e);
        $display("byte load sgn=1: ack_cycle=%0d rdata=%h", ac, rd);
        n_checks++; if (ac !== 3) begin n_fail++; $display("FAIL byte_ld_ack: got %0d expected 3", ac); end
        n_checks++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL byte_ld_sext: got %h expected ffffff80", rd); end
        do_req(0, 32'h20, 32'h0, 0, 2'b00, 0, ac, rd, e);
        $display("byte load sgn=0: rdata=%h", rd);
        n_checks++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL byte_ld_zext: got %h expected 00000080", rd); end
        do_req(0, 32'h22, 32'h1234_8001, 1, 2'b01, 0, ac, rd, e);
        $display("half store 0x22: ack_cycle=%0d", ac);
        n_checks++; if ({ac, n_beats, b_data[0], b_data[1]} !== {32'd3, 32'd2, 16'h8001}) begin n_fail++; $display("FAIL half_st: got ack=%0d n=%0d bytes=%h%h expected 3/2/8001", ac, n_beats, b_data[0], b_data[1]); end
        do_req(0, 32'h22, 32'h0, 0, 2'b01, 1, ac, rd, e);
        $display("half load sgn=1: ack_cycle=%0d rdata=%h", ac, rd);
        n_checks++; if ({ac, rd} !== {32'd4, 32'hFFFF8001}) begin n_fail++; $display("FAIL half_ld_sext: got ack=%0d rdata=%h expected 4/ffff8001", ac, rd); end
        do_req(0, 32'h22, 32'h0, 0, 2'b01, 0, ac, rd, e);
        $display("half load sgn=0: rdata=%h", rd);
        n_checks++; if (rd !== 32'h00008001) begin n_fail++; $display("FAIL half_ld_zext: got %h expected 00008001", rd); end
    endtask

    task automatic test_errors();
        int ac; logic [31:0] rd; logic e;
        do_req(1, 32'h10, 32'h0, 0, 2'b11, 0, ac, rd, e);
        $display("size=11 on port1: ack_cycle=%0d err=%b beats=%0d", ac, e, n_beats);
        n_checks++; if ({ac, e, n_beats, rd} !== {32'd1, 1'b1, 32'd0, 32'h0}) begin n_fail++; $display("FAIL size11_err: got ack=%0d err=%b n=%0d rdata=%h expected 1/1/0/0", ac, e, n_beats, rd); end
`ifdef DMEM_ACCESS_CTRL_ALIGN_CHECK_EN
        do_req(0, 32'h13, 32'h0, 0, 2'b10, 0, ac, rd, e);
        $display("misaligned word load 0x13: ack_cycle=%0d err=%b beats=%0d", ac, e, n_beats);
        n_checks++; if ({ac, e, n_beats} !== {32'd1, 1'b1, 32'd0}) begin n_fail++; $display("FAIL misalign_err: got ack=%0d err=%b n=%0d expected 1/1/0", ac, e, n_beats); end
`else
        do_req(0, 32'hFE, 32'h0102_0304, 1, 2'b10, 0, ac, rd, e);
        $display("unaligned word store 0xFE: ack_cycle=%0d beats=%0d", ac, n_beats);
        n_checks++; if ({b_addr[0], b_addr[1], b_addr[2], b_addr[3]} !== 32'hFEFF0001) begin n_fail++; $display("FAIL wrap_addr: got %h%h%h%h expected feff0001", b_addr[0], b_addr[1], b_addr[2], b_addr[3]); end
        n_checks++; if ({ac, e, b_data[0], b_data[3]} !== {32'd5, 1'b0, 16'h0104}) begin n_fail++; $display("FAIL wrap_store: got ack=%0d err=%b d0=%h d3=%h expected 5/0/01/04", ac, e, b_data[0], b_data[3]); end
        do_req(0, 32'hFE, 32'h0, 0, 2'b10, 0, ac, rd, e);
        $display("unaligned word load 0xFE: rdata=%h", rd);
        n_checks++; if ({ac, rd} !== {32'd6, 32'h01020304}) begin n_fail++; $display("FAIL wrap_load: got ack=%0d rdata=%h expected 6/01020304", ac, rd); end
`endif
    endtask

    task automatic test_back_to_back();
        int a0, a1; logic [31:0] rd1; logic both;
        int ac; logic [31:0] rd; logic e;
        a0 = -1; a1 = -1; rd1 = 32'h0; both = 1'b0;
        req0 = 1; addr0 = 32'h30; wdata0 = 32'hCAFEF00D; we0 = 1; size0 = 2'b10; sgn0 = 0;
        for (int c = 1; c <= 20 && a1 < 0; c++) begin
            @(negedge clk);
            if (ack0 && ack1) both = 1'b1;
            if (ack0) begin a0 = c; req0 = 0; end
            if (ack1) begin a1 = c; rd1 = rdata; req1 = 0; end
            if (c == 2) begin req1 = 1; addr1 = 32'h30; we1 = 0; size1 = 2'b00; sgn1 = 0; end
        end
        req0 = 0; req1 = 0;
        @(negedge clk);
        $display("busy overlap: ack0_cycle=%0d ack1_cycle=%0d rdata1=%h", a0, a1, rd1);
        n_checks++; if (a0 !== 5) begin n_fail++; $display("FAIL b2b_ack0: got %0d expected 5", a0); end
        n_checks++; if ({a1, rd1} !== {32'd9, 32'h000000CA}) begin n_fail++; $display("FAIL b2b_ack1: got ack=%0d rdata=%h expected 9/000000ca", a1, rd1); end
        n_checks++; if (both !== 1'b0) begin n_fail++; $display("FAIL b2b_dual_ack: got %b expected 0", both); end
        do_req(1, 32'h31, 32'h0, 0, 2'b00, 0, ac, rd, e);
        n_checks++; if ({ac, rd} !== {32'd3, 32'h000000FE}) begin n_fail++; $display("FAIL port1_load: got ack=%0d rdata=%h expected 3/000000fe", ac, rd); end
    endtask

    task automatic test_ties();
        int seq [4]; int cyc [4]; int k; logic both;
        apply_reset();
        @(negedge clk);
        k = 0; both = 1'b0;
        req0 = 1; addr0 = 32'h20; we0 = 0; size0 = 2'b00; sgn0 = 0;
        req1 = 1; addr1 = 32'h22; we1 = 0; size1 = 2'b00; sgn1 = 0;
        for (int c = 1; c <= 40 && k < 4; c++) begin
            @(negedge clk);
            if (ack0 && ack1) both = 1'b1;
            if (ack0 || ack1) begin
                seq[k] = ack1 ? 1 : 0; cyc[k] = c; k++;
            end
        end
        req0 = 0; req1 = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            $display("tie grant %0d: port=%0d cycle=%0d", i, (i < k) ? seq[i] : -1, (i < k) ? cyc[i] : -1);
            n_checks++; if (i >= k || seq[i] !== (i % 2)) begin n_fail++; $display("FAIL tie_order%0d: got %0d expected %0d", i, (i < k) ? seq[i] : -1, i % 2); end
        end
        n_checks++; if (k < 2 || {cyc[0], cyc[1], both} !== {32'd3, 32'd7, 1'b0}) begin n_fail++; $display("FAIL tie_timing: got k=%0d c0=%0d c1=%0d both=%b expected 3/7/0", k, cyc[0], cyc[1], both); end
    endtask

    task automatic test_reset_mid_store();
        int ac; logic [31:0] rd; logic e; logic seen_ack;
        do_req(0, 32'h40, 32'hFFEE_A55A, 1, 2'b10, 0, ac, rd, e);
        req0 = 1; addr0 = 32'h40; wdata0 = 32'h1122_3344; we0 = 1; size0 = 2'b10; sgn0 = 0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if ({mem_en, mem_addr} !== {1'b1, 8'h41}) begin n_fail++; $display("FAIL rst_mid_beat: got en=%b addr=%h expected 1/41", mem_en, mem_addr); end
        rst = 0; req0 = 0;
        @(negedge clk);
        $display("reset mid-store: busy=%b mem_en=%b ack0=%b", busy, mem_en, ack0);
        n_checks++; if ({ack0, ack1, err, busy, mem_en, mem_we, mem_addr, mem_wdata, rdata} !== 54'h0) begin n_fail++; $display("FAIL rst_mid_outputs: got ack=%b%b err=%b busy=%b en=%b we=%b addr=%h wd=%h rd=%h expected all 0", ack0, ack1, err, busy, mem_en, mem_we, mem_addr, mem_wdata, rdata); end
        rst = 1;
        seen_ack = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack0 || ack1 || busy) seen_ack = 1'b1;
        end
        n_checks++; if (seen_ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_ack: got %b expected 0", seen_ack); end
        do_req(0, 32'h40, 32'h0, 0, 2'b10, 0, ac, rd, e);
        $display("reload 0x40 after reset: rdata=%h", rd);
        n_checks++; if (rd !== 32'h1122A55A) begin n_fail++; $display("FAIL rst_mid_mem: got %h expected 1122a55a", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_sign_ext();
        test_errors();
        test_back_to_back();
        test_ties();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
